// File: rtl/maxnet_done_tracker.sv
// MAXNET termination detector: waits for STABLE_ITERS consecutive "<=1 positive" beats or a timeout.
// Optional collapse (tie) detection is enabled by defining MAXNET_TIE_DETECT_EN.
module maxnet_done_tracker #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_ITER     = 16,
  parameter int STABLE_ITERS = 2,
  localparam int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int IT_W        = $clog2(MAX_ITER + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   act_valid,
  input  logic [N_CH*DATA_W-1:0] act_bus,
  input  logic                   done_ack,
  output logic                   busy,
  output logic                   done,
  output logic                   winner_vld,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   timeout,
  output logic                   tie,
  output logic [IT_W-1:0]        iter_count
);

  localparam int ST_W  = $clog2(STABLE_ITERS + 1);
  localparam int CNT_W = $clog2(N_CH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [IT_W-1:0]    iter_q, iter_nxt, iter_inc;
  logic [ST_W-1:0]    stable_q, stable_nxt;
  logic               win_vld_q, win_vld_nxt;
  logic [IDX_W-1:0]   win_idx_q, win_idx_nxt;
  logic               timeout_q, timeout_nxt;
  logic               tie_q, tie_nxt;
  logic [CNT_W-1:0]   pos_cnt;
  logic [IDX_W-1:0]   low_idx;
  logic [DATA_W-1:0]  chan;
  logic               settled, settle_hit, collapse;

  // Downward scan so the last hit recorded is the lowest positive channel
  always_comb begin
    pos_cnt = '0;
    low_idx = '0;
    chan    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      chan = act_bus[i*DATA_W +: DATA_W];
      if (!chan[DATA_W-1] && (chan != '0)) begin
        pos_cnt = pos_cnt + CNT_W'(1);
        low_idx = IDX_W'(i);
      end
    end
  end

  assign settled    = (pos_cnt <= CNT_W'(1));
  assign settle_hit = settled && (stable_q == ST_W'(STABLE_ITERS - 1));
  assign iter_inc   = (iter_q == IT_W'(MAX_ITER)) ? iter_q : iter_q + IT_W'(1);

`ifdef MAXNET_TIE_DETECT_EN
  logic prev_multi_q;

  // Remembers whether the previous valid beat had two or more positive channels
  always_ff @(posedge clk) begin
    if (!rst_n)
      prev_multi_q <= 1'b0;
    else if (state == IDLE && start)
      prev_multi_q <= 1'b0;
    else if (state == RUN && act_valid)
      prev_multi_q <= (pos_cnt >= CNT_W'(2));
  end

  assign collapse = act_valid && (pos_cnt == '0) && prev_multi_q;
`else
  assign collapse = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    iter_nxt    = iter_q;
    stable_nxt  = stable_q;
    win_vld_nxt = win_vld_q;
    win_idx_nxt = win_idx_q;
    timeout_nxt = timeout_q;
    tie_nxt     = tie_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RUN;
          iter_nxt    = '0;
          stable_nxt  = '0;
          win_vld_nxt = 1'b0;
          win_idx_nxt = '0;
          timeout_nxt = 1'b0;
          tie_nxt     = 1'b0;
        end
      end
      RUN: begin
        if (act_valid) begin
          iter_nxt   = iter_inc;
          stable_nxt = settled ? stable_q + ST_W'(1) : '0;
          // Priority: collapse, then settle, then timeout
          if (collapse) begin
            state_nxt   = DONE;
            tie_nxt     = 1'b1;
            win_vld_nxt = 1'b0;
            timeout_nxt = 1'b0;
          end else if (settle_hit) begin
            state_nxt   = DONE;
            win_vld_nxt = (pos_cnt == CNT_W'(1));
            win_idx_nxt = low_idx;
            timeout_nxt = 1'b0;
          end else if (iter_inc == IT_W'(MAX_ITER)) begin
            state_nxt   = DONE;
            timeout_nxt = 1'b1;
            win_vld_nxt = 1'b0;
          end
        end
      end
      DONE: begin
        if (done_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      iter_q    <= '0;
      stable_q  <= '0;
      win_vld_q <= 1'b0;
      win_idx_q <= '0;
      timeout_q <= 1'b0;
      tie_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      iter_q    <= iter_nxt;
      stable_q  <= stable_nxt;
      win_vld_q <= win_vld_nxt;
      win_idx_q <= win_idx_nxt;
      timeout_q <= timeout_nxt;
      tie_q     <= tie_nxt;
    end
  end

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign winner_vld = win_vld_q;
  assign winner_idx = win_idx_q;
  assign timeout    = timeout_q;
  assign tie        = tie_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_done_tracker.sv
// Self-checking bench for maxnet_done_tracker: table-driven vectors with an expected-result queue.
// Test 6 expectations follow MAXNET_TIE_DETECT_EN.
module tb_maxnet_done_tracker;

  logic         clk = 1'b0;
  logic         rst_n, start, act_valid, done_ack;
  logic [127:0] act_bus;
  logic         busy, done, winner_vld, timeout, tie;
  logic [1:0]   winner_idx;
  logic [4:0]   iter_count;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic       done, busy, wv;
    logic [1:0] idx;
    logic       to, tie;
    logic [4:0] iter;
  } exp_t;

  typedef struct packed {
    logic         rst_n, start, valid, ack;
    logic [127:0] bus;
    exp_t         exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t t1[8];

  maxnet_done_tracker #(.N_CH(4), .DATA_W(32), .MAX_ITER(16), .STABLE_ITERS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_valid(act_valid), .act_bus(act_bus),
    .done_ack(done_ack), .busy(busy), .done(done), .winner_vld(winner_vld),
    .winner_idx(winner_idx), .timeout(timeout), .tie(tie), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input int a0, input int a1, input int a2, input int a3);
    return {a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
  endfunction

  function automatic exp_t e(input logic d, input logic b, input logic wv, input logic [1:0] idx,
                             input logic to, input logic ti, input logic [4:0] it);
    exp_t r;
    r.done = d; r.busy = b; r.wv = wv; r.idx = idx; r.to = to; r.tie = ti; r.iter = it;
    return r;
  endfunction

  function automatic vec_t mv(input logic rn, input logic st, input logic va, input logic ak,
                              input logic [127:0] bus, input exp_t ex);
    vec_t v;
    v.rst_n = rn; v.start = st; v.valid = va; v.ack = ak; v.bus = bus; v.exp = ex;
    return v;
  endfunction

  task automatic checkOutput(input string name);
    exp_t got, want;
    got = {done, busy, winner_vld, winner_idx, timeout, tie, iter_count};
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("[TB] FAIL %s: no expected entry queued, got %h", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failed++;
        $display("[TB] FAIL %s: got done=%0b busy=%0b wv=%0b idx=%0d to=%0b tie=%0b iter=%0d, expected done=%0b busy=%0b wv=%0b idx=%0d to=%0b tie=%0b iter=%0d",
                 name, got.done, got.busy, got.wv, got.idx, got.to, got.tie, got.iter,
                 want.done, want.busy, want.wv, want.idx, want.to, want.tie, want.iter);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clk);
    rst_n     = v.rst_n;
    start     = v.start;
    act_valid = v.valid;
    done_ack  = v.ack;
    act_bus   = v.bus;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  // Drive a single beat in RUN and expect the given outputs
  task automatic beat(input logic [127:0] bus, input exp_t ex, input string name);
    applyStimulus(mv(1'b1, 1'b0, 1'b1, 1'b0, bus, ex), name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; act_valid = 1'b0; done_ack = 1'b0; act_bus = '0;

    // Test 1 table: reset, start, three beats, hold, ack, ack outside DONE
    t1[0] = mv(0, 0, 0, 0, '0,               e(0, 0, 0, 0, 0, 0, 0));
    t1[1] = mv(1, 1, 0, 0, '0,               e(0, 1, 0, 0, 0, 0, 0));
    t1[2] = mv(1, 0, 1, 0, mk(5, 3, 0, 0),   e(0, 1, 0, 0, 0, 0, 1));
    t1[3] = mv(1, 0, 1, 0, mk(2, 0, 0, 0),   e(0, 1, 0, 0, 0, 0, 2));
    t1[4] = mv(1, 0, 1, 0, mk(1, 0, 0, 0),   e(1, 0, 1, 0, 0, 0, 3));
    t1[5] = mv(1, 0, 0, 0, '0,               e(1, 0, 1, 0, 0, 0, 3));
    t1[6] = mv(1, 0, 0, 1, '0,               e(0, 0, 1, 0, 0, 0, 3));
    t1[7] = mv(1, 0, 0, 1, '0,               e(0, 0, 1, 0, 0, 0, 3));
    for (int i = 0; i < 8; i++) applyStimulus(t1[i], $sformatf("t1_step%0d", i));

    // Test 4: same beats with 3-cycle gaps; start pulses in RUN must be ignored
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "t4_start");
    beat(mk(5, 3, 0, 0), e(0, 1, 0, 0, 0, 0, 1), "t4_b1");
    for (int g = 0; g < 3; g++)
      applyStimulus(mv(1, 1, 0, 0, mk(1, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 1)), "t4_gap1");
    beat(mk(2, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 2), "t4_b2");
    for (int g = 0; g < 3; g++)
      applyStimulus(mv(1, 0, 0, 0, mk(9, 9, 0, 0), e(0, 1, 0, 0, 0, 0, 2)), "t4_gap2");
    beat(mk(1, 0, 0, 0), e(1, 0, 1, 0, 0, 0, 3), "t4_b3");
    applyStimulus(mv(1, 1, 1, 0, mk(0, 6, 0, 0), e(1, 0, 1, 0, 0, 0, 3)), "t4_done_hold");
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 1, 0, 0, 0, 3)), "t4_ack");

    // Test 2: sixteen unsettled beats reach timeout
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "t2_start");
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) beat(mk(4, 4, -1, 0), e(0, 1, 0, 0, 0, 0, 5'(k)), "t2_beat");
      else        beat(mk(4, 4, -1, 0), e(1, 0, 0, 0, 1, 0, 5'd16), "t2_timeout");
    end
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 0, 0, 1, 0, 16)), "t2_ack");

    // Test 3: settle completes on beat 16 and beats the timeout
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "t3_start");
    for (int k = 1; k <= 14; k++) beat(mk(4, 4, -1, 0), e(0, 1, 0, 0, 0, 0, 5'(k)), "t3_beat");
    beat(mk(0, 0, 7, 0), e(0, 1, 0, 0, 0, 0, 15), "t3_b15");
    beat(mk(0, 0, 7, 0), e(1, 0, 1, 2, 0, 0, 16), "t3_b16");
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 1, 2, 0, 0, 16)), "t3_ack");

    // Stable counter restarts after an unsettled beat; most-negative value is not positive
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "ts_start");
    beat(mk(1, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 1), "ts_b1");
    beat(mk(1, 1, 0, 0), e(0, 1, 0, 0, 0, 0, 2), "ts_b2");
    beat(mk(32'h8000_0000, 1, 0, 0), e(0, 1, 0, 0, 0, 0, 3), "ts_b3");
    beat(mk(-5, 0, 0, 1), e(1, 0, 1, 3, 0, 0, 4), "ts_b4");
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 1, 3, 0, 0, 4)), "ts_ack");

    // Test 5: reset mid-run wins over start/valid, then a fresh run works
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "t5_start");
    beat(mk(5, 3, 0, 0), e(0, 1, 0, 0, 0, 0, 1), "t5_b1");
    applyStimulus(mv(0, 1, 1, 0, mk(1, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0)), "t5_reset");
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "t5_restart");
    beat(mk(0, 2, 0, 0), e(0, 1, 0, 0, 0, 0, 1), "t5_b1b");
    beat(mk(0, 2, 0, 0), e(1, 0, 1, 1, 0, 0, 2), "t5_b2b");
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 1, 1, 0, 0, 2)), "t5_ack");

    // Test 6: tie then all-zero beat
    applyStimulus(mv(1, 1, 0, 0, '0, e(0, 1, 0, 0, 0, 0, 0)), "t6_start");
    beat(mk(3, 3, 0, 0), e(0, 1, 0, 0, 0, 0, 1), "t6_b1");
`ifdef MAXNET_TIE_DETECT_EN
    beat(mk(0, 0, 0, 0), e(1, 0, 0, 0, 0, 1, 2), "t6_collapse");
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 0, 0, 0, 1, 2)), "t6_ack");
`else
    beat(mk(0, 0, 0, 0), e(0, 1, 0, 0, 0, 0, 2), "t6_b2");
    beat(mk(0, 0, 0, 0), e(1, 0, 0, 0, 0, 0, 3), "t6_settle");
    applyStimulus(mv(1, 0, 0, 1, '0, e(0, 0, 0, 0, 0, 0, 3)), "t6_ack");
`endif

    @(negedge clk);
    start = 1'b0; act_valid = 1'b0; done_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
